// File: rtl/hazard_resolve_unit.sv
// Pipeline hazard control: registered EX forwarding selects, load-use stall,
// taken-branch flush and saturating performance counters.
module hazard_resolve_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             R1_EX_Related,
  input  logic             R1_MEM_Related,
  input  logic             R2_EX_Related,
  input  logic             R2_MEM_Related,
  input  logic             EX_MemToReg,
  input  logic             EX_BranchTaken,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [1:0]       R1_Fwd_Sel,
  output logic [1:0]       R2_Fwd_Sel,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Fwd_Cnt,
  output logic             Dbg_State
);

  typedef enum logic {ST_RUN = 1'b0, ST_LSTALL = 1'b1} state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic             w_load_use;
  logic [1:0]       w_r1_sel;
  logic [1:0]       w_r2_sel;
  logic [1:0]       r_r1_sel;
  logic [1:0]       r_r2_sel;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;

  assign w_load_use = EX_MemToReg & (R1_EX_Related | R2_EX_Related);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A taken branch squashes the stalled instruction, so it aborts any stall.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (EX_BranchTaken) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use) begin
            w_cnt_nxt   = STALL_RELOAD;
            w_state_nxt = MULTI_STALL ? ST_LSTALL : ST_RUN;
          end
        end
        ST_LSTALL: begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    PC_En      = 1'b1;
    IFID_En    = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (r_state == ST_LSTALL || w_load_use) begin
      PC_En      = 1'b0;
      IFID_En    = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  // EX match wins over MEM: it is the younger producer of the register.
  always_comb begin
    w_r1_sel = SEL_RF;
    w_r2_sel = SEL_RF;
    if (!IDEX_Flush) begin
      if (R1_EX_Related)       w_r1_sel = SEL_EXM;
      else if (R1_MEM_Related) w_r1_sel = SEL_MWB;
      if (R2_EX_Related)       w_r2_sel = SEL_EXM;
      else if (R2_MEM_Related) w_r2_sel = SEL_MWB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r1_sel    <= SEL_RF;
      r_r2_sel    <= SEL_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      r_r1_sel <= w_r1_sel;
      r_r2_sel <= w_r2_sel;
      if (!PC_En && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (EX_BranchTaken && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if ((w_r1_sel != SEL_RF || w_r2_sel != SEL_RF) && !(&r_fwd_cnt))
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
    end
  end

  assign R1_Fwd_Sel = r_r1_sel;
  assign R2_Fwd_Sel = r_r2_sel;
  assign Stall_Cnt  = r_stall_cnt;
  assign Flush_Cnt  = r_flush_cnt;
  assign Fwd_Cnt    = r_fwd_cnt;
  assign Dbg_State  = r_state;

endmodule

// File: tb/tb_hazard_resolve_unit.sv
// Bench for hazard_resolve_unit: three instances (1, 3 and 7 stall cycles, the
// last with 4-bit counters) share one stimulus and are checked against a model.
module tb_hazard_resolve_unit;

  localparam int NS[3] = '{1, 3, 7};
  localparam int WS[3] = '{16, 16, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r1e = 1'b0, r1m = 1'b0, r2e = 1'b0, r2m = 1'b0, ldex = 1'b0, br = 1'b0;

  logic        pc_en [3];
  logic        if_en [3];
  logic        if_fl [3];
  logic        ex_fl [3];
  logic        dbg   [3];
  logic [1:0]  s1_q  [3];
  logic [1:0]  s2_q  [3];
  logic [15:0] stc   [3];
  logic [15:0] flc   [3];
  logic [15:0] fwc   [3];
  logic [3:0]  sat_st, sat_fl, sat_fw;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining forced stall cycles, expected selects, counters.
  int rem [3];
  int e_s1 [3];
  int e_s2 [3];
  int e_st [3];
  int e_fl [3];
  int e_fw [3];
  bit snap_pc [3];
  bit snap_en [3];
  bit snap_ifl [3];
  bit snap_xfl [3];

  always #5 clk = ~clk;

  hazard_resolve_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_n1 (
    .clk(clk), .rst_n(rst_n),
    .R1_EX_Related(r1e), .R1_MEM_Related(r1m), .R2_EX_Related(r2e), .R2_MEM_Related(r2m),
    .EX_MemToReg(ldex), .EX_BranchTaken(br),
    .PC_En(pc_en[0]), .IFID_En(if_en[0]), .IFID_Flush(if_fl[0]), .IDEX_Flush(ex_fl[0]),
    .R1_Fwd_Sel(s1_q[0]), .R2_Fwd_Sel(s2_q[0]),
    .Stall_Cnt(stc[0]), .Flush_Cnt(flc[0]), .Fwd_Cnt(fwc[0]), .Dbg_State(dbg[0])
  );

  hazard_resolve_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_n3 (
    .clk(clk), .rst_n(rst_n),
    .R1_EX_Related(r1e), .R1_MEM_Related(r1m), .R2_EX_Related(r2e), .R2_MEM_Related(r2m),
    .EX_MemToReg(ldex), .EX_BranchTaken(br),
    .PC_En(pc_en[1]), .IFID_En(if_en[1]), .IFID_Flush(if_fl[1]), .IDEX_Flush(ex_fl[1]),
    .R1_Fwd_Sel(s1_q[1]), .R2_Fwd_Sel(s2_q[1]),
    .Stall_Cnt(stc[1]), .Flush_Cnt(flc[1]), .Fwd_Cnt(fwc[1]), .Dbg_State(dbg[1])
  );

  hazard_resolve_unit #(.LOAD_STALL_CYCLES(7), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .R1_EX_Related(r1e), .R1_MEM_Related(r1m), .R2_EX_Related(r2e), .R2_MEM_Related(r2m),
    .EX_MemToReg(ldex), .EX_BranchTaken(br),
    .PC_En(pc_en[2]), .IFID_En(if_en[2]), .IFID_Flush(if_fl[2]), .IDEX_Flush(ex_fl[2]),
    .R1_Fwd_Sel(s1_q[2]), .R2_Fwd_Sel(s2_q[2]),
    .Stall_Cnt(sat_st), .Flush_Cnt(sat_fl), .Fwd_Cnt(sat_fw), .Dbg_State(dbg[2])
  );

  assign stc[2] = {12'd0, sat_st};
  assign flc[2] = {12'd0, sat_fl};
  assign fwc[2] = {12'd0, sat_fw};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  function automatic int sel_of(input bit bubble, input bit ex, input bit mem);
    if (bubble) return 0;
    if (ex)     return 1;
    if (mem)    return 2;
    return 0;
  endfunction

  task automatic model_comb(input int k, output bit pc, output bit en, output bit ifl,
                            output bit xfl, output int nrem);
    bit lu;
    lu = ldex & (r1e | r2e);
    pc = 1'b1; en = 1'b1; ifl = 1'b0; xfl = 1'b0; nrem = 0;
    if (br) begin
      ifl = 1'b1; xfl = 1'b1;
    end else if (rem[k] > 0) begin
      pc = 1'b0; en = 1'b0; xfl = 1'b1; nrem = rem[k] - 1;
    end else if (lu) begin
      pc = 1'b0; en = 1'b0; xfl = 1'b1; nrem = NS[k] - 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; e_s1[k] = 0; e_s2[k] = 0; e_st[k] = 0; e_fl[k] = 0; e_fw[k] = 0;
    end
  endtask

  task automatic check_comb(input int k, output int nrem, output bit pc_o, output bit xfl_o);
    bit pc, en, ifl, xfl;
    model_comb(k, pc, en, ifl, xfl, nrem);
    chk($sformatf("pc_en[%0d]", k), int'(pc_en[k]), int'(pc));
    chk($sformatf("ifid_en[%0d]", k), int'(if_en[k]), int'(en));
    chk($sformatf("ifid_flush[%0d]", k), int'(if_fl[k]), int'(ifl));
    chk($sformatf("idex_flush[%0d]", k), int'(ex_fl[k]), int'(xfl));
    chk($sformatf("state[%0d]", k), int'(dbg[k]), (rem[k] > 0) ? 1 : 0);
    snap_pc[k] = pc_en[k]; snap_en[k] = if_en[k];
    snap_ifl[k] = if_fl[k]; snap_xfl[k] = ex_fl[k];
    pc_o = pc; xfl_o = xfl;
  endtask

  task automatic check_regs(input int k);
    chk($sformatf("r1_sel[%0d]", k), int'(s1_q[k]), e_s1[k]);
    chk($sformatf("r2_sel[%0d]", k), int'(s2_q[k]), e_s2[k]);
    chk($sformatf("stall_cnt[%0d]", k), int'(stc[k]), e_st[k]);
    chk($sformatf("flush_cnt[%0d]", k), int'(flc[k]), e_fl[k]);
    chk($sformatf("fwd_cnt[%0d]", k), int'(fwc[k]), e_fw[k]);
  endtask

  task automatic step(input bit a_r1e, input bit a_r1m, input bit a_r2e, input bit a_r2m,
                      input bit a_ld, input bit a_br);
    int nrem [3];
    int ns1 [3];
    int ns2 [3];
    bit pc, xfl;
    @(negedge clk);
    r1e = a_r1e; r1m = a_r1m; r2e = a_r2e; r2m = a_r2m; ldex = a_ld; br = a_br;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_comb(k, nrem[k], pc, xfl);
      ns1[k] = sel_of(xfl, r1e, r1m);
      ns2[k] = sel_of(xfl, r2e, r2m);
      if (!pc) e_st[k] = sat_inc(e_st[k], WS[k]);
      if (br)  e_fl[k] = sat_inc(e_fl[k], WS[k]);
      if (ns1[k] != 0 || ns2[k] != 0) e_fw[k] = sat_inc(e_fw[k], WS[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rem[k] = nrem[k]; e_s1[k] = ns1[k]; e_s2[k] = ns2[k];
      check_regs(k);
    end
  endtask

  // Reset is pulsed between clock edges so it must act without one.
  task automatic async_reset();
    int nrem;
    bit pc, xfl;
    #1;
    r1e = 0; r1m = 0; r2e = 0; r2m = 0; ldex = 0; br = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_comb(k, nrem, pc, xfl);
      check_regs(k);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int nrem;
    bit pc, xfl;
    int low;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      check_comb(k, nrem, pc, xfl);
      check_regs(k);
    end
    chk("reset pc_en literal", int'(pc_en[0]), 1);
    chk("reset fwd literal", int'(s1_q[1]), 0);
    rst_n = 1'b1;

    // ALU to ALU back-to-back
    step(1, 0, 0, 0, 0, 0);
    chk("alu pc_en", int'(snap_pc[0]), 1);
    chk("alu r1_sel", int'(s1_q[0]), 1);
    chk("alu r2_sel", int'(s2_q[0]), 0);
    chk("alu fwd_cnt", int'(fwc[0]), 1);

    // Distance-2 on both operands, then EX overriding MEM on rs
    async_reset();
    step(0, 1, 0, 1, 0, 0);
    chk("dist2 r1_sel", int'(s1_q[0]), 2);
    chk("dist2 r2_sel", int'(s2_q[0]), 2);
    step(1, 1, 0, 1, 0, 0);
    chk("prio r1_sel", int'(s1_q[0]), 1);
    chk("prio r2_sel", int'(s2_q[0]), 2);

    // Load-use with one stall cycle
    async_reset();
    step(0, 0, 1, 0, 1, 0);
    chk("lu1 pc_en", int'(snap_pc[0]), 0);
    chk("lu1 ifid_en", int'(snap_en[0]), 0);
    chk("lu1 idex_flush", int'(snap_xfl[0]), 1);
    chk("lu1 r2_sel bubble", int'(s2_q[0]), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("lu1 resume pc_en", int'(snap_pc[0]), 1);
    chk("lu1 r2_sel mem", int'(s2_q[0]), 2);
    chk("lu1 stall_cnt", int'(stc[0]), 1);

    // Load-use with three stall cycles
    async_reset();
    low = 0;
    step(0, 0, 1, 0, 1, 0); low += snap_pc[1] ? 0 : 1;
    step(0, 0, 0, 0, 0, 0); low += snap_pc[1] ? 0 : 1;
    step(0, 0, 0, 0, 0, 0); low += snap_pc[1] ? 0 : 1;
    chk("lu3 low cycles", low, 3);
    step(0, 0, 0, 0, 0, 0);
    chk("lu3 released", int'(snap_pc[1]), 1);
    chk("lu3 stall_cnt", int'(stc[1]), 3);

    // Branch during the second stall cycle
    async_reset();
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("br pc_en", int'(snap_pc[1]), 1);
    chk("br ifid_flush", int'(snap_ifl[1]), 1);
    chk("br idex_flush", int'(snap_xfl[1]), 1);
    chk("br state run", int'(dbg[1]), 0);
    chk("br stall_cnt", int'(stc[1]), 1);
    chk("br flush_cnt", int'(flc[1]), 1);

    // Reset in the middle of a stall
    async_reset();
    step(1, 0, 0, 0, 1, 0);
    chk("midstall state", int'(dbg[1]), 1);
    async_reset();
    chk("midstall reset pc_en", int'(pc_en[1]), 1);
    chk("midstall reset state", int'(dbg[1]), 0);

    // Saturation of the 4-bit stall counter
    async_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 0);
    chk("sat stall_cnt 4b", int'(stc[2]), 15);
    chk("sat stall_cnt 16b", int'(stc[0]), 20);

    // Randomized traffic
    async_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_resolve_unit.md
Name: hazard_resolve_unit

Overview:
- Consumer of the per-operand correlation flags (R1/R2 × EX/MEM) produced by the correlation detector in ID.
- Turns those flags into registered forwarding selects for the EX stage, load-use stall control for PC and IF/ID, and bubble/flush control for ID/EX.
- Handles taken-branch flush and keeps saturating performance counters.
- Sits between the ID-stage detector and the pipeline register/PC enables of the 5-stage MIPS pipeline.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- R1_EX_Related  input  1  rs matches the instruction currently in EX
- R1_MEM_Related  input  1  rs matches the instruction currently in MEM
- R2_EX_Related  input  1  rt matches EX
- R2_MEM_Related  input  1  rt matches MEM
- EX_MemToReg  input  1  instruction in EX is a load
- EX_BranchTaken  input  1  branch/jump resolved taken in EX
- PC_En  output  1  PC write enable
- IFID_En  output  1  IF/ID register enable
- IFID_Flush  output  1  clear IF/ID to NOP
- IDEX_Flush  output  1  clear ID/EX to NOP (bubble)
- R1_Fwd_Sel  output  2  EX-stage rs source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
- R2_Fwd_Sel  output  2  same for rt
- Stall_Cnt  output  CNT_W  load-use stall cycles
- Flush_Cnt  output  CNT_W  taken-branch flushes
- Fwd_Cnt  output  CNT_W  instructions entering EX with any non-zero forward select

Behaviour:
- Reset (async, rst_n=0): state RUN, stall counter 0, R1_Fwd_Sel=R2_Fwd_Sel=00, all perf counters 0. Combinational outputs then evaluate to PC_En=1, IFID_En=1, IFID_Flush=0, IDEX_Flush=0 unless inputs dictate otherwise.
- load_use = EX_MemToReg & (R1_EX_Related | R2_EX_Related).
- FSM states: RUN, LSTALL.
  - RUN, no branch, load_use=1:
    - PC_En=0, IFID_En=0, IDEX_Flush=1.
    - Load cnt with LOAD_STALL_CYCLES-1.
    - Go to LSTALL if LOAD_STALL_CYCLES>1; otherwise stay in RUN.
    - The next cycle re-evaluates with the load in MEM.
  - LSTALL:
    - PC_En=0, IFID_En=0, IDEX_Flush=1.
    - cnt decrements each cycle; exit to RUN when cnt==1.
  - EX_BranchTaken=1 in any state:
    - IFID_Flush=1, IDEX_Flush=1, PC_En=1, IFID_En=1.
    - Abort any stall: state→RUN, cnt→0.
    - Branch has priority over load_use in the same cycle.
- Forward select registers update every clk edge:
  - Bubble cycle (IDEX_Flush=1): both load 00.
  - Otherwise: Rx_Fwd_Sel ← 01 if Rx_EX_Related, else 10 if Rx_MEM_Related, else 00. EX priority over MEM when both are set.
  - Result is aligned with the instruction now in EX.
  - A load in EX never yields 01 on a non-bubble cycle, because load_use forces a bubble.
- Counters (saturate at all-ones, never wrap):
  - Stall_Cnt +1 per cycle with PC_En=0.
  - Flush_Cnt +1 per cycle with EX_BranchTaken=1.
  - Fwd_Cnt +1 per clk edge where either loaded select ≠00.
- Reset asserted mid-stall returns to RUN immediately. The first cycle after release is a normal RUN cycle.
- Flag inputs are assumed pre-qualified: register 0 and unused operands are already masked by the detector.

Test Plan:
- ALU→ALU back-to-back:
  - Stimulus: R1_EX_Related=1, EX_MemToReg=0.
  - Required: no stall (PC_En=1); after next edge R1_Fwd_Sel=01, R2_Fwd_Sel=00; Fwd_Cnt=1.
- Distance-2 dependency, both operands:
  - Stimulus: R1_MEM_Related=R2_MEM_Related=1.
  - Required: both selects 10 after the edge.
  - Same stimulus plus R1_EX_Related=1: R1_Fwd_Sel=01, R2_Fwd_Sel=10.
- Load-use, LOAD_STALL_CYCLES=1:
  - Stimulus: EX_MemToReg=1, R2_EX_Related=1 for one cycle; next cycle R2_MEM_Related=1 only.
  - Required: cycle 0: PC_En=0, IFID_En=0, IDEX_Flush=1, selects load 00.
  - Required: cycle 1: PC_En=1, R2_Fwd_Sel loads 10; Stall_Cnt=1.
- Load-use, LOAD_STALL_CYCLES=3:
  - Required: PC_En low for exactly 3 consecutive cycles; Stall_Cnt=3.
- Branch during LSTALL (LOAD_STALL_CYCLES=3):
  - Stimulus: EX_BranchTaken=1 in stall cycle 2.
  - Required: that cycle PC_En=1, IFID_Flush=1, IDEX_Flush=1; FSM back to RUN; Stall_Cnt=1; Flush_Cnt=1.
- Reset and saturation:
  - Stimulus: rst_n low mid-LSTALL.
  - Required: outputs return to reset values without a clock edge.
  - Stimulus: CNT_W=4, 20 stall cycles.
  - Required: Stall_Cnt holds at 15.
